// File: rtl/sram_vector_reader.sv
// Streams SIZE_N 128-bit elements out of a 16-bit-wide SRAM, eight words per element.
// Optional word checksum is built when VEC_READ_CHECKSUM_EN is defined; otherwise checksum is tied to 0.
module sram_vector_reader #(
    parameter int SIZE_N    = 64,
    parameter int READ_WAIT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    output logic         busy,
    output logic         ready,
    input  logic [17:0]  storeAddr,
    input  logic [15:0]  sramDataRead,
    output logic [17:0]  sramAddr,
    output logic         sramOutEnable,
    output logic         sramWriteEnable,
    output logic [127:0] elemData,
    output logic [7:0]   elemIndex,
    output logic         elemValid,
    input  logic         elemReady,
    output logic [15:0]  checksum,
    output logic [2:0]   dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE, S_ELEM, S_WAIT, S_CAPT, S_LOAD, S_PRESENT, S_DONE, S_FIN
    } state_t;

    localparam logic [7:0] LAST_I    = 8'(SIZE_N);
    localparam logic [3:0] WAIT_LAST = (READ_WAIT > 0) ? 4'(READ_WAIT - 1) : 4'd0;
    // With no read wait the address phase goes straight to capture.
    localparam state_t     AFTER_ADDR = (READ_WAIT > 0) ? S_WAIT : S_CAPT;

    state_t         state_q, state_d;
    logic [17:0]    base;
    logic [7:0]     i;
    logic [2:0]     k;
    logic [3:0]     wcnt;
    logic [127:0]   asm_q;

    assign sramWriteEnable = 1'b1;
    assign dbg_state       = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Element stream: an element transfers on any clock where elemValid && elemReady;
    // while elemValid is high elemData/elemIndex stay frozen, elemReady alone does nothing.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (enable) state_d = S_ELEM;
            S_ELEM:    state_d = (i == LAST_I) ? S_DONE : AFTER_ADDR;
            S_WAIT:    if (wcnt == WAIT_LAST) state_d = S_CAPT;
            S_CAPT:    state_d = (k == 3'd7) ? S_LOAD : AFTER_ADDR;
            S_LOAD:    state_d = S_PRESENT;
            S_PRESENT: if (elemReady) state_d = S_ELEM;
            S_DONE:    state_d = S_FIN;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy          <= 1'b0;
            ready         <= 1'b0;
            sramAddr      <= '0;
            sramOutEnable <= 1'b1;
            elemData      <= '0;
            elemIndex     <= '0;
            elemValid     <= 1'b0;
            base          <= '0;
            i             <= '0;
            k             <= '0;
            wcnt          <= '0;
            asm_q         <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (enable) begin
                    base          <= storeAddr;
                    i             <= '0;
                    busy          <= 1'b1;
                    ready         <= 1'b0;
                    sramOutEnable <= 1'b0;
                end
                S_ELEM: if (i != LAST_I) begin
                    k        <= '0;
                    wcnt     <= '0;
                    asm_q    <= '0;
                    sramAddr <= base + {7'd0, i, 3'b000};
                end
                S_WAIT: wcnt <= wcnt + 4'd1;
                S_CAPT: begin
                    // Words arrive low first; shifting in from the top leaves word k at [16k+15:16k].
                    asm_q <= {sramDataRead, asm_q[127:16]};
                    k     <= k + 3'd1;
                    wcnt  <= '0;
                    if (k != 3'd7) sramAddr <= sramAddr + 18'd1;
                end
                S_LOAD: begin
                    elemData  <= asm_q;
                    elemIndex <= i;
                    elemValid <= 1'b1;
                end
                S_PRESENT: if (elemReady) begin
                    elemValid <= 1'b0;
                    i         <= i + 8'd1;
                end
                S_DONE: begin
                    busy          <= 1'b0;
                    sramOutEnable <= 1'b1;
                end
                S_FIN: ready <= 1'b1;
                default: ;
            endcase
        end
    end

`ifdef VEC_READ_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                              checksum <= '0;
        else if (state_q == S_IDLE && enable)   checksum <= '0;
        else if (state_q == S_CAPT)             checksum <= checksum + sramDataRead;
    end
`else
    assign checksum = 16'd0;
`endif

endmodule

// File: tb/tb_sram_vector_reader.sv
// Bench for sram_vector_reader: scoreboarded element stream on a SIZE_N=4/READ_WAIT=1 instance,
// plus a SIZE_N=2/READ_WAIT=0 instance for latency and checksum.
module tb_sram_vector_reader;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [15:0] mem [0:262143];

    // instance a: SIZE_N=4, READ_WAIT=1
    logic         enable, elemReady;
    logic [17:0]  storeAddr, sramAddr;
    logic [15:0]  sramDataRead, checksum;
    logic         busy, ready, sramOutEnable, sramWriteEnable, elemValid;
    logic [127:0] elemData;
    logic [7:0]   elemIndex;
    logic [2:0]   dbg_state;

    // instance b: SIZE_N=2, READ_WAIT=0
    logic         b_enable, b_elemReady;
    logic [17:0]  b_storeAddr, b_sramAddr;
    logic [15:0]  b_sramDataRead, b_checksum;
    logic         b_busy, b_ready, b_sramOutEnable, b_sramWriteEnable, b_elemValid;
    logic [127:0] b_elemData;
    logic [7:0]   b_elemIndex;
    logic [2:0]   b_dbg_state;

    assign sramDataRead   = mem[sramAddr];
    assign b_sramDataRead = mem[b_sramAddr];

    sram_vector_reader #(.SIZE_N(4), .READ_WAIT(1)) dut (
        .clk(clk), .reset(reset), .enable(enable), .busy(busy), .ready(ready),
        .storeAddr(storeAddr), .sramDataRead(sramDataRead), .sramAddr(sramAddr),
        .sramOutEnable(sramOutEnable), .sramWriteEnable(sramWriteEnable),
        .elemData(elemData), .elemIndex(elemIndex), .elemValid(elemValid),
        .elemReady(elemReady), .checksum(checksum), .dbg_state(dbg_state)
    );

    sram_vector_reader #(.SIZE_N(2), .READ_WAIT(0)) dut_b (
        .clk(clk), .reset(reset), .enable(b_enable), .busy(b_busy), .ready(b_ready),
        .storeAddr(b_storeAddr), .sramDataRead(b_sramDataRead), .sramAddr(b_sramAddr),
        .sramOutEnable(b_sramOutEnable), .sramWriteEnable(b_sramWriteEnable),
        .elemData(b_elemData), .elemIndex(b_elemIndex), .elemValid(b_elemValid),
        .elemReady(b_elemReady), .checksum(b_checksum), .dbg_state(b_dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] exp_q[$];
    logic [7:0]   exp_idx_q[$];
    logic [127:0] mon_d;
    logic [7:0]   mon_i;
    logic [7:0]   b_exp_idx;

    function automatic logic [127:0] model_elem(input logic [17:0] b, input int idx);
        logic [127:0] r;
        logic [17:0]  a;
        r = '0;
        for (int kk = 0; kk < 8; kk++) begin
            a = b + 18'(idx * 8 + kk);
            r[16*kk +: 16] = mem[a];
        end
        return r;
    endfunction

    // scoreboard for instance a
    always @(negedge clk) begin
        if (!reset && elemValid && elemReady) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL elem_unexpected: got index=%0d data=%h, required no element", elemIndex, elemData);
            end else begin
                mon_d = exp_q.pop_front();
                mon_i = exp_idx_q.pop_front();
                if (elemData !== mon_d || elemIndex !== mon_i) begin
                    n_err++;
                    $display("FAIL elem_data: got index=%0d data=%h, required index=%0d data=%h",
                             elemIndex, elemData, mon_i, mon_d);
                end
            end
        end
    end

    // instance b: every word is 0xFFFF, indices must run 0,1
    always @(negedge clk) begin
        if (!reset && b_elemValid && b_elemReady) begin
            n_vec++;
            if (b_elemData !== {128{1'b1}} || b_elemIndex !== b_exp_idx) begin
                n_err++;
                $display("FAIL b_elem: got index=%0d data=%h, required index=%0d all ones",
                         b_elemIndex, b_elemData, b_exp_idx);
            end
            b_exp_idx = b_exp_idx + 8'd1;
        end
    end

    task automatic start_run(input logic [17:0] addr, input int push);
        @(posedge clk); #1;
        storeAddr = addr;
        enable = 1'b1;
        for (int e = 0; e < push; e++) begin
            exp_q.push_back(model_elem(addr, e));
            exp_idx_q.push_back(8'(e));
        end
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int c = 0;
        while (!ready && c < budget) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_timeout: ready=%b after %0d cycles, required 1", ready, c);
        end
    endtask

    task automatic check_reset_values(input string tag);
        n_vec++;
        if (busy !== 1'b0 || ready !== 1'b0 || sramAddr !== 18'd0 || sramOutEnable !== 1'b1 ||
            sramWriteEnable !== 1'b1 || elemData !== 128'd0 || elemIndex !== 8'd0 ||
            elemValid !== 1'b0 || checksum !== 16'd0) begin
            n_err++;
            $display("FAIL %s: busy=%b ready=%b addr=%h oe=%b we=%b data=%h idx=%0d valid=%b cs=%h, required reset values",
                     tag, busy, ready, sramAddr, sramOutEnable, sramWriteEnable, elemData, elemIndex, elemValid, checksum);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        enable = 1'b0; elemReady = 1'b0; storeAddr = '0;
        b_enable = 1'b0; b_elemReady = 1'b0; b_storeAddr = '0;
        b_exp_idx = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_state");
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic;
        int cnt = 0;
        logic [15:0] exp_cs;
        for (int j = 0; j < 32; j++) mem[18'h100 + 18'(j)] = 16'(j);
        elemReady = 1'b1;
        start_run(18'h100, 4);
        while (!elemValid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        n_vec++;
        if (cnt != 19 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_latency: got %0d cycles busy=%b, required 19 cycles busy=1", cnt, busy);
        end
        n_vec++;
        if (elemData !== 128'h0007_0006_0005_0004_0003_0002_0001_0000 || elemIndex !== 8'd0) begin
            n_err++;
            $display("FAIL basic_elem0: got idx=%0d data=%h, required idx=0 data=00070006000500040003000200010000",
                     elemIndex, elemData);
        end
        wait_ready(300);
`ifdef VEC_READ_CHECKSUM_EN
        exp_cs = 16'h01F0;
`else
        exp_cs = 16'h0000;
`endif
        n_vec++;
        if (busy !== 1'b0 || sramOutEnable !== 1'b1 || exp_q.size() != 0 || checksum !== exp_cs) begin
            n_err++;
            $display("FAIL basic_done: busy=%b oe=%b pending=%0d cs=%h, required busy=0 oe=1 pending=0 cs=%h",
                     busy, sramOutEnable, exp_q.size(), checksum, exp_cs);
        end
        repeat (5) @(negedge clk);
        n_vec++;
        if (ready !== 1'b1) begin
            n_err++;
            $display("FAIL ready_hold: got %b, required 1", ready);
        end
    endtask

    task automatic test_backpressure;
        logic [127:0] sd;
        logic [7:0]   si;
        logic [17:0]  sa;
        int c;
        elemReady = 1'b0;
        start_run(18'h100, 4);
        n_vec++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_flags: ready=%b busy=%b, required ready=0 busy=1", ready, busy);
        end
        for (int e = 0; e < 4; e++) begin
            c = 0;
            while (!elemValid && c < 100) begin
                @(negedge clk);
                c++;
            end
            n_vec++;
            if (elemValid !== 1'b1 || elemIndex !== 8'(e)) begin
                n_err++;
                $display("FAIL bp_present: valid=%b idx=%0d, required valid=1 idx=%0d", elemValid, elemIndex, e);
            end
            if (e == 1) begin
                sd = elemData; si = elemIndex; sa = sramAddr;
                for (int s = 0; s < 20; s++) begin
                    @(negedge clk);
                    n_vec++;
                    if (elemValid !== 1'b1 || elemData !== sd || elemIndex !== si || sramAddr !== sa) begin
                        n_err++;
                        $display("FAIL bp_stable: cycle %0d valid=%b idx=%0d addr=%h, required valid=1 idx=%0d addr=%h",
                                 s, elemValid, elemIndex, sramAddr, si, sa);
                    end
                end
            end
            @(posedge clk); #1;
            elemReady = 1'b1;
            @(posedge clk); #1;
            elemReady = 1'b0;
        end
        wait_ready(300);
        elemReady = 1'b1;
    endtask

    task automatic test_wrap;
        logic [17:0] rec [8];
        logic [17:0] last;
        logic [17:0] ex;
        int n = 0;
        int c = 0;
        for (int j = 0; j < 4; j++) mem[18'h3FFFC + 18'(j)] = 16'($urandom_range(0, 65535));
        for (int j = 0; j < 32; j++) mem[18'(j)] = 16'($urandom_range(0, 65535));
        elemReady = 1'b1;
        last = sramAddr;
        start_run(18'h3FFFC, 4);
        while (n < 8 && c < 100) begin
            @(negedge clk);
            c++;
            if (sramAddr !== last) begin
                rec[n] = sramAddr;
                last = sramAddr;
                n++;
            end
        end
        for (int j = 0; j < 8; j++) begin
            ex = 18'h3FFFC + 18'(j);
            n_vec++;
            if (j >= n || rec[j] !== ex) begin
                n_err++;
                $display("FAIL wrap_addr[%0d]: got %h (seen %0d), required %h", j, rec[j], n, ex);
            end
        end
        wait_ready(300);
    endtask

    task automatic test_reset_mid_run;
        int c = 0;
        elemReady = 1'b1;
        start_run(18'h100, 4);
        while (sramAddr !== 18'h115 && c < 200) begin
            @(negedge clk);
            c++;
        end
        n_vec++;
        if (sramAddr !== 18'h115) begin
            n_err++;
            $display("FAIL mid_reach: addr=%h, required 00115", sramAddr);
        end
        reset = 1'b1;
        #1;
        check_reset_values("mid_reset");
        exp_q.delete();
        exp_idx_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (10) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0 || elemValid !== 1'b0 || ready !== 1'b0) begin
            n_err++;
            $display("FAIL no_autostart: busy=%b valid=%b ready=%b, required 0 0 0", busy, elemValid, ready);
        end
        start_run(18'h100, 4);
        wait_ready(300);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL restart_count: pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_enable_while_busy;
        elemReady = 1'b1;
        start_run(18'h100, 4);
        repeat (10) @(negedge clk);
        @(posedge clk); #1;
        storeAddr = 18'h3000;
        enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
        wait_ready(300);
        repeat (40) @(negedge clk);
        n_vec++;
        if (exp_q.size() != 0 || busy !== 1'b0 || ready !== 1'b1) begin
            n_err++;
            $display("FAIL busy_enable: pending=%0d busy=%b ready=%b, required 0 0 1", exp_q.size(), busy, ready);
        end
    endtask

    task automatic test_checksum_b;
        int cnt = 0;
        int c = 0;
        logic [15:0] exp_cs;
        for (int j = 0; j < 16; j++) mem[18'h2000 + 18'(j)] = 16'hFFFF;
        b_elemReady = 1'b1;
        b_exp_idx = '0;
        @(posedge clk); #1;
        b_storeAddr = 18'h2000;
        b_enable = 1'b1;
        @(posedge clk); #1;
        b_enable = 1'b0;
        while (!b_elemValid && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        n_vec++;
        if (cnt != 11) begin
            n_err++;
            $display("FAIL b_latency: got %0d cycles, required 11", cnt);
        end
        while (!b_ready && c < 200) begin
            @(negedge clk);
            c++;
        end
`ifdef VEC_READ_CHECKSUM_EN
        exp_cs = 16'hFFF0;
`else
        exp_cs = 16'h0000;
`endif
        n_vec++;
        if (b_ready !== 1'b1 || b_checksum !== exp_cs || b_exp_idx !== 8'd2) begin
            n_err++;
            $display("FAIL b_checksum: ready=%b cs=%h elems=%0d, required ready=1 cs=%h elems=2",
                     b_ready, b_checksum, b_exp_idx, exp_cs);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_reset_mid_run();
        test_enable_while_busy();
        test_checksum_b();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
